// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit: fetch PC, one-outstanding memory requests, fetch buffer
module ifu_fetch #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            rsp_valid,
  input  logic [XLEN-1:0] rsp_data,
  input  logic            rsp_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic [1:0]      out_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_ACCESS   = 2'd1;
  localparam logic [1:0] ERR_MISALIGN = 2'd2;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP,
    S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] opc_q, opc_d;

  logic [XLEN-1:0] buf_pc   [DEPTH];
  logic [XLEN-1:0] buf_inst [DEPTH];
  logic [1:0]      buf_err  [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;

  logic            full;
  logic            misaligned;
  logic            req_fire;
  logic            pop;
  logic            push;
  logic [XLEN-1:0] push_pc;
  logic [XLEN-1:0] push_inst;
  logic [1:0]      push_err;
  logic            outstanding;

  // Request and buffer outputs come straight from registers.
  assign full       = (count == DEPTH_C);
  assign misaligned = (fpc_q[1:0] != 2'b00);
  assign req_valid  = (state_q == S_REQ) && !full && !misaligned;
  assign req_addr   = fpc_q;
  assign req_fire   = req_valid && req_ready;

  assign out_valid  = (count != '0);
  assign out_pc     = buf_pc[rd_ptr];
  assign out_inst   = buf_inst[rd_ptr];
  assign out_err    = buf_err[rd_ptr];
  assign pop        = out_valid && out_ready && !redirect_valid;

  always_comb begin
    state_d     = state_q;
    fpc_d       = fpc_q;
    opc_d       = opc_q;
    push        = 1'b0;
    push_pc     = fpc_q;
    push_inst   = '0;
    push_err    = ERR_NONE;
    outstanding = 1'b0;

    case (state_q)
      S_REQ: begin
        if (misaligned) begin
          if (!full) begin
            push     = 1'b1;
            push_pc  = fpc_q;
            push_err = ERR_MISALIGN;
            state_d  = S_HALT;
          end
        end else if (req_fire) begin
          opc_d   = fpc_q;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rsp_valid) begin
          push      = 1'b1;
          push_pc   = opc_q;
          push_inst = rsp_data;
          push_err  = rsp_err ? ERR_ACCESS : ERR_NONE;
          fpc_d     = opc_q + XLEN'(4);
          state_d   = rsp_err ? S_HALT : S_REQ;
        end
      end
      S_DROP: begin
        if (rsp_valid) begin
          state_d = S_REQ;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    // A redirect overrides everything; DROP swallows the response still owed by memory.
    if (redirect_valid) begin
      push        = 1'b0;
      fpc_d       = redirect_pc;
      outstanding = ((state_q == S_WAIT) && !rsp_valid) ||
                    ((state_q == S_DROP) && !rsp_valid) ||
                    ((state_q == S_REQ)  && req_fire);
      state_d     = outstanding ? S_DROP : S_REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      fpc_q   <= RESET_PC;
      opc_q   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_pc[i]   <= '0;
        buf_inst[i] <= '0;
        buf_err[i]  <= ERR_NONE;
      end
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      opc_q   <= opc_d;
      if (redirect_valid) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          buf_pc[wr_ptr]   <= push_pc;
          buf_inst[wr_ptr] <= push_inst;
          buf_err[wr_ptr]  <= push_err;
          wr_ptr           <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - scoreboard bench for ifu_fetch with a one-cycle memory responder
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [1:0]  out_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  ifu_fetch #(
    .XLEN(32),
    .RESET_PC(32'h8000_0000),
    .DEPTH(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_inst(out_inst),
    .out_err(out_err),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  err;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] req_log[$];
  int          checks = 0;
  int          errors = 0;
  logic        mem_auto = 1'b1;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_ent(input logic [31:0] pc, input logic [31:0] inst, input logic [1:0] err);
    ent_t e;
    e.pc = pc;
    e.inst = inst;
    e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic run_until_reqs(input int n, input int budget);
    int k;
    k = 0;
    while (req_log.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    chk("req_count_reached", 32'(req_log.size()), 32'(n));
    req_ready = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick(1);
      k++;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick(2);
  endtask

  task automatic do_reset(input logic auto_mode);
    rst_n = 1'b0;
    req_ready = 1'b0;
    redirect_valid = 1'b0;
    rsp_valid = 1'b0;
    rsp_err = 1'b0;
    rsp_data = 32'h0;
    mem_auto = auto_mode;
    tick(2);
    req_log.delete();
  endtask

  // Memory model: answers one cycle after each accepted request; data tags the address.
  initial begin
    logic        hs;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      hs = rst_n && req_valid && req_ready;
      a = req_addr;
      if (hs) req_log.push_back(a);
      @(posedge clk);
      #1;
      if (mem_auto) begin
        rsp_valid = hs;
        rsp_data = hs ? {a[15:0], 16'h0013} : 32'h0;
        rsp_err = hs && err_en && (a == err_addr);
      end
    end
  end

  // Monitor: every accepted buffer head is compared with the oldest expected entry.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual pc=%h inst=%h required none", out_pc, out_inst);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", out_pc, e.pc);
          chk("out_inst", out_inst, e.inst);
          chk("out_err", 32'(out_err), 32'(e.err));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data = 32'h0;
    rsp_err = 1'b0;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    tick(2);

    chk("rst_req_valid", 32'(req_valid), 32'd1);
    chk("rst_req_addr", req_addr, 32'h8000_0000);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_out_err", 32'(out_err), 32'd0);

    // Streaming fetch from reset.
    expect_ent(32'h8000_0000, 32'h0000_0013, 2'd0);
    expect_ent(32'h8000_0004, 32'h0004_0013, 2'd0);
    expect_ent(32'h8000_0008, 32'h0008_0013, 2'd0);
    req_ready = 1'b1;
    rst_n = 1'b1;
    run_until_reqs(3, 40);
    wait_empty(40);
    chk("t1_addr0", req_log[0], 32'h8000_0000);
    chk("t1_addr1", req_log[1], 32'h8000_0004);
    chk("t1_addr2", req_log[2], 32'h8000_0008);

    // Backpressure fills the buffer and stalls requests.
    do_reset(1'b1);
    out_ready = 1'b0;
    req_ready = 1'b1;
    rst_n = 1'b1;
    tick(8);
    chk("t2_req_stalled", 32'(req_valid), 32'd0);
    chk("t2_out_valid", 32'(out_valid), 32'd1);
    chk("t2_req_count", 32'(req_log.size()), 32'd2);
    expect_ent(32'h8000_0000, 32'h0000_0013, 2'd0);
    expect_ent(32'h8000_0004, 32'h0004_0013, 2'd0);
    expect_ent(32'h8000_0008, 32'h0008_0013, 2'd0);
    out_ready = 1'b1;
    run_until_reqs(3, 40);
    wait_empty(40);
    chk("t2_resume_addr", req_log[2], 32'h8000_0008);

    // Redirect while waiting: the owed response is dropped.
    do_reset(1'b0);
    req_ready = 1'b1;
    rst_n = 1'b1;
    tick(1);
    req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_1000;
    tick(1);
    redirect_valid = 1'b0;
    chk("t3_drop_req_valid", 32'(req_valid), 32'd0);
    chk("t3_flush_out_valid", 32'(out_valid), 32'd0);
    tick(2);
    chk("t3_drop_hold", 32'(req_valid), 32'd0);
    rsp_valid = 1'b1;
    rsp_data = 32'hdead_beef;
    tick(1);
    rsp_valid = 1'b0;
    chk("t3_req_valid", 32'(req_valid), 32'd1);
    chk("t3_req_addr", req_addr, 32'h8000_1000);
    expect_ent(32'h8000_1000, 32'h1000_0013, 2'd0);
    mem_auto = 1'b1;
    req_ready = 1'b1;
    run_until_reqs(2, 40);
    wait_empty(40);

    // Redirect coincident with the response: no DROP.
    do_reset(1'b0);
    req_ready = 1'b1;
    rst_n = 1'b1;
    tick(1);
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_data = 32'h1111_1111;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_1000;
    tick(1);
    rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    chk("t4_req_valid", 32'(req_valid), 32'd1);
    chk("t4_req_addr", req_addr, 32'h8000_1000);
    chk("t4_out_valid", 32'(out_valid), 32'd0);
    expect_ent(32'h8000_1000, 32'h1000_0013, 2'd0);
    mem_auto = 1'b1;
    req_ready = 1'b1;
    run_until_reqs(2, 40);
    wait_empty(40);

    // Access fault halts fetch; misaligned redirect yields one error entry.
    do_reset(1'b1);
    err_en = 1'b1;
    err_addr = 32'h8000_0004;
    expect_ent(32'h8000_0000, 32'h0000_0013, 2'd0);
    expect_ent(32'h8000_0004, 32'h0004_0013, 2'd1);
    req_ready = 1'b1;
    rst_n = 1'b1;
    tick(12);
    chk("t5_halt_req_count", 32'(req_log.size()), 32'd2);
    chk("t5_halt_req_valid", 32'(req_valid), 32'd0);
    wait_empty(40);
    expect_ent(32'h8000_0002, 32'h0000_0000, 2'd2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0002;
    tick(1);
    redirect_valid = 1'b0;
    wait_empty(40);
    tick(4);
    chk("t5_misalign_no_req", 32'(req_log.size()), 32'd2);
    chk("t5_misalign_req_valid", 32'(req_valid), 32'd0);
    err_en = 1'b0;
    req_ready = 1'b0;

    // Reset in the middle of a transaction.
    do_reset(1'b0);
    out_ready = 1'b0;
    req_ready = 1'b1;
    rst_n = 1'b1;
    tick(1);
    rsp_valid = 1'b1;
    rsp_data = 32'h0000_0013;
    tick(1);
    rsp_valid = 1'b0;
    tick(1);
    chk("t6_buffered", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    req_ready = 1'b0;
    tick(1);
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_req_valid", 32'(req_valid), 32'd1);
    chk("t6_req_addr", req_addr, 32'h8000_0000);
    chk("t6_out_pc", out_pc, 32'h0);
    chk("t6_out_inst", out_inst, 32'h0);
    rst_n = 1'b1;
    rsp_valid = 1'b1;
    rsp_data = 32'h2222_2222;
    tick(1);
    rsp_valid = 1'b0;
    tick(2);
    chk("t6_late_rsp_ignored", 32'(out_valid), 32'd0);
    req_log.delete();
    expect_ent(32'h8000_0000, 32'h0000_0013, 2'd0);
    out_ready = 1'b1;
    mem_auto = 1'b1;
    req_ready = 1'b1;
    run_until_reqs(1, 40);
    wait_empty(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Parametrised instruction fetch unit for the NPC core. Holds the fetch PC, issues one-outstanding word requests to instruction memory over a valid/ready request channel with a valid-only response channel, and buffers fetched {pc, inst, err} entries in a small FIFO. The FIFO feeds the decode stage through a valid/ready handshake. A redirect port, driven by branch/jump/trap resolution, flushes in-flight work and restarts fetch at a new PC.

## Interface
Parameters:
- XLEN, 32, width of PC, address and instruction data
- RESET_PC, 32'h8000_0000, fetch address after reset
- DEPTH, 2, fetch buffer entries (power of two, ≥2)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  out  1  fetch request valid
- req_ready  in  1  memory accepts request
- req_addr  out  XLEN  word-aligned fetch address
- rsp_valid  in  1  response valid, one per accepted request
- rsp_data  in  XLEN  fetched instruction
- rsp_err  in  1  access fault on this response
- out_valid  out  1  buffer head valid
- out_ready  in  1  decode accepts head
- out_pc  out  XLEN  PC of head entry
- out_inst  out  XLEN  instruction of head entry
- out_err  out  2  0 none, 1 access fault, 2 misaligned PC
- redirect_valid  in  1  restart fetch
- redirect_pc  in  XLEN  new fetch PC

## Operation
- Registers: fpc (fetch PC), opc (outstanding PC), FSM state, FIFO storage, read/write pointers, count.
- FSM states: REQ, WAIT, DROP, HALT.
- REQ: req_valid = (count < DEPTH) && !fpc-misaligned; req_addr = fpc. On handshake: opc<=fpc, go WAIT. If fpc[1:0]!=0 and FIFO not full: push {fpc, 0, err=2}, go HALT, no request issued.
- WAIT: req_valid=0. On rsp_valid: push {opc, rsp_data, rsp_err?1:0}, fpc<=opc+4 (mod 2^XLEN, wraps to 0), next REQ; if rsp_err, next HALT.
- DROP: req_valid=0; wait for rsp_valid, discard it, go REQ.
- HALT: no requests until redirect.
- Space rule: request issued only if count < DEPTH at REQ; at most one outstanding, so no overflow.
- Redirect (highest priority, any state): FIFO flushed (count<=0, pointers reset), fpc<=redirect_pc. Next state: DROP if a request is outstanding after this edge (state WAIT without rsp_valid this cycle, or REQ with handshake this cycle); otherwise REQ. Push and pop in the redirect cycle are suppressed.
- In REQ without handshake, redirect changes req_addr next cycle; memory tolerates address change on an unaccepted request.
- FIFO: out_valid = (count!=0); pop on out_valid&&out_ready; push and pop in same cycle allowed, count unchanged.
- rsp_valid in REQ or HALT is ignored (stray response after reset).

## Timing
- Reset (rst_n=0 at edge): fpc=RESET_PC, state=REQ, count=0, pointers 0. Outputs during/after reset: req_valid=1 (FIFO empty), req_addr=RESET_PC, out_valid=0, out_pc/out_inst/out_err=0 (storage cleared).
- Reset mid-operation discards outstanding request and buffer contents; no response is expected for it.
- req_valid, req_addr and out_* are functions of registers only, with no combinational path from any input.
- Minimum latency: request handshake in cycle N, rsp_valid in N+1, out_valid in N+2. Throughput with always-ready memory: one instruction per 2 cycles.
- Redirect in cycle N: out_valid=0 in N+1; req_valid with redirect_pc in N+1 (non-DROP case).

## Test plan
- Reset, memory ready, rsp 1 cycle later with 0x00000013 → req_addr 0x80000000, 0x80000004, 0x80000008; outputs in order with correct pc, out_err=0.
- out_ready=0, DEPTH=2 → exactly 2 entries buffered, req_valid stays 0; releasing out_ready drains 0x80000000 then 0x80000004, fetch resumes at 0x80000008.
- Redirect to 0x80001000 in WAIT → pending response discarded (DROP), buffer empty, next req_addr 0x80001000, first out_pc 0x80001000.
- Redirect coincident with rsp_valid → response dropped, no DROP state, req_addr 0x80001000 next cycle.
- rsp_err=1 at 0x80000004 → entry out_err=1, no further requests until redirect; redirect to 0x80000002 → single entry out_pc 0x80000002, out_err=2, no memory request.
- Assert rst_n=0 while WAIT with 1 buffered entry → next cycle out_valid=0, req_addr=0x80000000, late rsp_valid ignored.
